// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM
// state encoding, exception cause codes and the store-side lane helpers.
package lsu_pkg;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [1:0] CAUSE_LD_MISALIGN = 2'd0;
  localparam logic [1:0] CAUSE_ST_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL     = 2'd2;

  // Access size lives in funct3[1:0] for both loads and stores.
  function automatic logic [3:0] store_ben(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across all lanes; ben selects the live one.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'd1:    return a[0];
      2'd2:    return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic store, input logic [2:0] f3);
    if (store) return f3 >= 3'd3;
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the byte/half lane addressed by addr_lo out
// of the 32-bit memory word and sign- or zero-extends it per funct3.
//   rdata   in  32  raw memory word
//   addr_lo in  2   byte offset within the word
//   funct3  in  3   load type (LB/LH/LW/LBU/LHU)
//   data    out 32  extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic signed [7:0]  byte_lane;
  logic signed [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      data = 32'(byte_lane);
      LH:      data = 32'(half_lane);
      LBU:     data = {24'd0, byte_lane};
      LHU:     data = {16'd0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between execute and the data-memory port.
//   i_clk, i_rst_n            clock, async active-low reset
//   i_valid/o_ready           request handshake from execute
//   i_store,i_funct3,i_addr,i_wdata,i_rd   request fields
//   o_dm_ren/wen/ben/addr/wdata, i_dm_rdata, i_mem_ready   memory port
//   o_wb_valid/rd/data        one-cycle load result to writeback
//   o_exc/o_exc_cause/o_exc_addr   one-cycle exception report
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_store,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [4:0]        i_rd,
  output logic              o_dm_ren,
  output logic              o_dm_wen,
  output logic [3:0]        o_dm_ben,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic [31:0]       o_dm_wdata,
  input  logic [31:0]       i_dm_rdata,
  input  logic              i_mem_ready,
  output logic              o_wb_valid,
  output logic [4:0]        o_wb_rd,
  output logic [31:0]       o_wb_data,
  output logic              o_exc,
  output logic [1:0]        o_exc_cause,
  output logic [31:0]       o_exc_addr
);

  state_e             state;
  logic               req_store_p1;
  logic [2:0]         req_f3_p1;
  logic [ADDR_W+1:0]  req_addr_p1;
  logic [31:0]        req_wdata_p1;
  logic [4:0]         req_rd_p1;
  logic [31:0]        load_data;
  logic               in_req;
  logic               accept;

  assign accept  = i_valid && (state == IDLE);
  assign in_req  = (state == REQ);
  assign o_ready = (state == IDLE);

  // Request capture: data only, qualified by the FSM state.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      req_store_p1 <= i_store;
      req_f3_p1    <= i_funct3;
      req_addr_p1  <= i_addr[ADDR_W+1:0];
      req_wdata_p1 <= i_wdata;
      req_rd_p1    <= i_rd;
    end
  end

  // Memory port: strobes follow i_mem_ready combinationally so no strobe
  // can assert while memory is stalled; the rest is zero outside REQ.
  assign o_dm_wen   = in_req && req_store_p1 && i_mem_ready;
  assign o_dm_ren   = in_req && !req_store_p1 && i_mem_ready;
  assign o_dm_addr  = in_req ? req_addr_p1[ADDR_W+1:2] : '0;
  assign o_dm_ben   = in_req ? store_ben(req_f3_p1, req_addr_p1[1:0]) : 4'd0;
  assign o_dm_wdata = (in_req && req_store_p1) ? store_lanes(req_f3_p1, req_wdata_p1) : 32'd0;

  lsu_load_align u_align (
    .rdata   (i_dm_rdata),
    .addr_lo (req_addr_p1[1:0]),
    .funct3  (req_f3_p1),
    .data    (load_data)
  );

  // Control FSM with registered writeback/exception outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_wb_valid  <= 1'b0;
      o_wb_rd     <= 5'd0;
      o_wb_data   <= 32'd0;
      o_exc       <= 1'b0;
      o_exc_cause <= 2'd0;
      o_exc_addr  <= 32'd0;
    end else begin
      o_wb_valid <= 1'b0;
      o_exc      <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (is_illegal(i_store, i_funct3)) begin
              o_exc       <= 1'b1;
              o_exc_cause <= CAUSE_ILLEGAL;
              o_exc_addr  <= i_addr;
            end else if (is_misaligned(i_funct3, i_addr[1:0])) begin
              o_exc       <= 1'b1;
              o_exc_cause <= i_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
              o_exc_addr  <= i_addr;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (i_mem_ready) state <= req_store_p1 ? IDLE : RESP;
        end
        RESP: begin
          // i_dm_rdata is valid now, one cycle after the read strobe.
          o_wb_valid <= 1'b1;
          o_wb_rd    <= req_rd_p1;
          o_wb_data  <= load_data;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [4:0]  i_rd;
  logic        o_dm_ren;
  logic        o_dm_wen;
  logic [3:0]  o_dm_ben;
  logic [13:0] o_dm_addr;
  logic [31:0] o_dm_wdata;
  logic [31:0] i_dm_rdata = 32'd0;
  logic        i_mem_ready;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_exc;
  logic [1:0]  o_exc_cause;
  logic [31:0] o_exc_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wen_cnt = 0, ren_cnt = 0, wb_cnt = 0, overlap = 0;
  int wen_q[$];
  int ren_q[$];
  logic [31:0] rd_word = 32'd0;
  logic [31:0] wb_last = 32'd0;

  load_store_unit #(.ADDR_W(14)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_store(i_store), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rd(i_rd), .o_dm_ren(o_dm_ren), .o_dm_wen(o_dm_wen), .o_dm_ben(o_dm_ben),
    .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata), .i_dm_rdata(i_dm_rdata),
    .i_mem_ready(i_mem_ready), .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd),
    .o_wb_data(o_wb_data), .o_exc(o_exc), .o_exc_cause(o_exc_cause),
    .o_exc_addr(o_exc_addr)
  );

  always #5 i_clk = ~i_clk;

  // SPRAM model: one-cycle read latency, garbage when not read.
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    i_dm_rdata <= o_dm_ren ? rd_word : 32'hDEAD_BEEF;
  end

  always @(negedge i_clk) begin
    if (o_dm_wen) begin wen_cnt++; wen_q.push_back(cyc); end
    if (o_dm_ren) begin ren_cnt++; ren_q.push_back(cyc); end
    if (o_dm_wen && o_dm_ren) overlap++;
    if (o_wb_valid) begin wb_cnt++; wb_last = o_wb_data; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present a request in the current cycle; returns in the following cycle.
  task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic [4:0] rd);
    i_valid = 1'b1; i_store = st; i_funct3 = f3; i_addr = a; i_wdata = d; i_rd = rd;
    @(negedge i_clk);
    chk("req_ready", o_ready, 1'b1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] exp);
    req(1'b0, f3, a, 32'd0, rd);
    @(negedge i_clk);
    chk({tag, "_ren"}, o_dm_ren, 1'b1);
    chk({tag, "_addr"}, 32'(o_dm_addr), (a >> 2) & 32'h3FFF);
    tick();
    @(negedge i_clk);
    chk({tag, "_wb_early"}, o_wb_valid, 1'b0);
    chk({tag, "_busy"}, o_ready, 1'b0);
    tick();
    @(negedge i_clk);
    chk({tag, "_wb_valid"}, o_wb_valid, 1'b1);
    chk({tag, "_wb_data"}, o_wb_data, exp);
    chk({tag, "_wb_rd"}, 32'(o_wb_rd), 32'(rd));
    chk({tag, "_ready"}, o_ready, 1'b1);
    tick();
  endtask

  task automatic do_exc(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] cause);
    int s0;
    s0 = wen_cnt + ren_cnt;
    req(st, f3, a, 32'h1234_5678, 5'd1);
    @(negedge i_clk);
    chk({tag, "_exc"}, o_exc, 1'b1);
    chk({tag, "_cause"}, 32'(o_exc_cause), 32'(cause));
    chk({tag, "_addr"}, o_exc_addr, a);
    chk({tag, "_ready"}, o_ready, 1'b1);
    tick();
    @(negedge i_clk);
    chk({tag, "_exc_pulse"}, o_exc, 1'b0);
    chk({tag, "_no_strobe"}, 32'(wen_cnt + ren_cnt - s0), 32'd0);
    tick();
  endtask

  initial begin
    int s0, nw, nr, wb0;
    int acc[3];
    logic ok;
    i_rst_n = 1'b0; i_valid = 1'b0; i_store = 1'b0; i_funct3 = 3'd0;
    i_addr = 32'd0; i_wdata = 32'd0; i_rd = 5'd0; i_mem_ready = 1'b1;

    // Reset state
    tick(); tick();
    @(negedge i_clk);
    chk("rst_wb_valid", o_wb_valid, 1'b0);
    chk("rst_exc", o_exc, 1'b0);
    chk("rst_ben", 32'(o_dm_ben), 32'd0);
    chk("rst_wdata", o_dm_wdata, 32'd0);
    chk("rst_strobes", {o_dm_wen, o_dm_ren}, 2'b00);
    tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", o_ready, 1'b1);
    tick();

    // SB lane replication
    req(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 5'd0);
    @(negedge i_clk);
    chk("sb_wen", o_dm_wen, 1'b1);
    chk("sb_ren", o_dm_ren, 1'b0);
    chk("sb_addr", 32'(o_dm_addr), 32'h0400);
    chk("sb_ben", 32'(o_dm_ben), 32'h8);
    chk("sb_wdata", o_dm_wdata, 32'hABAB_ABAB);
    tick();
    @(negedge i_clk);
    chk("sb_wen_off", o_dm_wen, 1'b0);
    chk("sb_ready", o_ready, 1'b1);
    chk("sb_ben_idle", 32'(o_dm_ben), 32'd0);
    tick();

    // SH upper half
    req(1'b1, 3'd1, 32'h0000_0012, 32'h5555_BEEF, 5'd0);
    @(negedge i_clk);
    chk("sh_ben", 32'(o_dm_ben), 32'hC);
    chk("sh_wdata", o_dm_wdata, 32'hBEEF_BEEF);
    tick();

    // Load extraction
    rd_word = 32'h8012_3456;
    do_load("lb", 3'd0, 32'h1003, 5'd3, 32'hFFFF_FF80);
    do_load("lbu", 3'd4, 32'h1003, 5'd4, 32'h0000_0080);
    do_load("lhu", 3'd5, 32'h1002, 5'd5, 32'h0000_8012);
    do_load("lh_neg", 3'd1, 32'h1002, 5'd6, 32'hFFFF_8012);
    do_load("lh_pos", 3'd1, 32'h1000, 5'd7, 32'h0000_3456);
    do_load("lb_lane1", 3'd0, 32'h1001, 5'd8, 32'h0000_0034);
    do_load("lw", 3'd2, 32'h1000, 5'd9, 32'h8012_3456);

    // Exceptions
    do_exc("lw_mis", 1'b0, 3'd2, 32'h0000_2002, 2'd0);
    do_exc("lh_mis", 1'b0, 3'd1, 32'h0000_2001, 2'd0);
    do_exc("sh_mis", 1'b1, 3'd1, 32'h0000_0003, 2'd1);
    do_exc("sw_mis", 1'b1, 3'd2, 32'h0000_2001, 2'd1);
    do_exc("ld_f3_3", 1'b0, 3'd3, 32'h0000_2000, 2'd2);
    do_exc("st_f3_4", 1'b1, 3'd4, 32'h0000_2000, 2'd2);

    // SW with memory stalled three cycles; address wraps to 14 bits
    i_mem_ready = 1'b0;
    s0 = wen_cnt;
    req(1'b1, 3'd2, 32'h0001_2344, 32'hCAFE_F00D, 5'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("stall_wen", o_dm_wen, 1'b0);
      chk("stall_addr", 32'(o_dm_addr), 32'h08D1);
      chk("stall_ben", 32'(o_dm_ben), 32'hF);
      chk("stall_wdata", o_dm_wdata, 32'hCAFE_F00D);
      chk("stall_busy", o_ready, 1'b0);
      tick();
    end
    i_mem_ready = 1'b1;
    @(negedge i_clk);
    chk("stall_wen_on", o_dm_wen, 1'b1);
    tick();
    @(negedge i_clk);
    chk("stall_done", o_ready, 1'b1);
    chk("stall_wen_count", 32'(wen_cnt - s0), 32'd1);
    tick();

    // Reset during RESP
    rd_word = 32'h1111_2222;
    wb0 = wb_cnt;
    req(1'b0, 3'd2, 32'h0000_0040, 32'd0, 5'd10);
    tick();
    i_rst_n = 1'b0;
    #1;
    chk("rr_ready", o_ready, 1'b1);
    chk("rr_ren", o_dm_ren, 1'b0);
    tick();
    @(negedge i_clk);
    chk("rr_wb_valid", o_wb_valid, 1'b0);
    chk("rr_wb_data", o_wb_data, 32'd0);
    chk("rr_wb_rd", 32'(o_wb_rd), 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("rr_no_wb", 32'(wb_cnt - wb0), 32'd0);
    do_load("rr_after", 3'd2, 32'h0000_0044, 5'd11, 32'h1111_2222);

    // Back-to-back SW, LW, SW with i_valid held high
    rd_word = 32'h1357_9BDF;
    nw = wen_q.size();
    nr = ren_q.size();
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_store = (k != 1); i_funct3 = 3'd2;
      i_addr = 32'h100 + 32'(k) * 4; i_wdata = 32'hA000_0000 + 32'(k); i_rd = 5'd12;
      ok = 1'b0;
      acc[k] = 0;
      for (int w = 0; w < 20 && !ok; w++) begin
        @(negedge i_clk);
        if (o_ready) begin ok = 1'b1; acc[k] = cyc; end
        else tick();
      end
      chk("b2b_accept_timeout", ok, 1'b1);
      tick();
    end
    i_valid = 1'b0;
    repeat (6) tick();
    chk("b2b_lw_accept", 32'(acc[1] - acc[0]), 32'd2);
    chk("b2b_sw2_accept", 32'(acc[2] - acc[0]), 32'd5);
    chk("b2b_wen0", 32'(wen_q[nw]), 32'(acc[0] + 1));
    chk("b2b_ren", 32'(ren_q[nr]), 32'(acc[0] + 3));
    chk("b2b_wen1", 32'(wen_q[nw + 1]), 32'(acc[0] + 6));
    chk("b2b_wen_total", 32'(wen_q.size() - nw), 32'd2);
    chk("b2b_wb_data", wb_last, 32'h1357_9BDF);
    chk("no_overlap", 32'(overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the data-memory port of main_mem (i_dm_* / o_dm_rdata / o_ready).
- Accepts one RV32I load or store per handshake and computes the word address, byte enables and lane-replicated write data.
- Waits for memory ready, then captures the 1-cycle-latency SPRAM read data and returns sign- or zero-extended load results to writeback.
- Detects misaligned and illegal-funct3 accesses and reports them as exceptions without touching memory.

Parameters:
- ADDR_W, 14: word-address width driven to memory. Byte address bits [ADDR_W+1:2] are used; higher bits are ignored, so the address wraps.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_valid  in  1  request valid from execute
- o_ready  out  1  LSU can accept a request this cycle
- i_store  in  1  1=store, 0=load
- i_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW)
- i_addr  in  32  byte address (rs1+imm)
- i_wdata  in  32  store data (rs2)
- i_rd  in  5  load destination register
- o_dm_ren  out  1  memory read strobe
- o_dm_wen  out  1  memory write strobe
- o_dm_ben  out  4  byte enables
- o_dm_addr  out  ADDR_W  word address
- o_dm_wdata  out  32  lane-replicated write data
- i_dm_rdata  in  32  read data, valid the cycle after o_dm_ren
- i_mem_ready  in  1  memory accepts an access (main_mem o_ready)
- o_wb_valid  out  1  one-cycle load-result pulse
- o_wb_rd  out  5  load destination
- o_wb_data  out  32  extended load data
- o_exc  out  1  one-cycle exception pulse
- o_exc_cause  out  2  0=load misaligned, 1=store misaligned, 2=illegal funct3
- o_exc_addr  out  32  faulting byte address

Behaviour:
- Reset (i_rst_n=0, async): state IDLE, all registered outputs 0, any pending access dropped. o_ready=1 after reset releases.
- States: IDLE, REQ, RESP. o_ready=1 only in IDLE.
- IDLE, on i_valid: register the request, then check it.
  - Misaligned (H: addr[0]!=0; W: addr[1:0]!=0) or illegal funct3 (load 3/6/7, store >=3): stay in IDLE; o_exc, o_exc_cause and o_exc_addr are registered and pulse in cycle T+1; no memory strobe.
  - Otherwise: go to REQ.
- REQ:
  - o_dm_addr, o_dm_ben and o_dm_wdata are driven from the registered request and held stable.
  - o_dm_wen/o_dm_ren = (store/load) & i_mem_ready. A strobe never asserts while i_mem_ready=0. Stay in REQ until ready.
  - On the ready cycle: a store goes to IDLE (complete); a load goes to RESP.
- RESP: format i_dm_rdata and register it, so o_wb_valid, o_wb_rd and o_wb_data are valid for exactly one cycle next cycle; state goes to IDLE.
- Store encoding:
  - SB: ben = 1<<addr[1:0], wdata = {4{byte}}.
  - SH: ben = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - SW: ben = 1111.
- Load extraction:
  - Byte lane = rdata[8*addr[1:0]+:8]; half lane = addr[1] ? rdata[31:16] : rdata[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Latency and throughput:
  - Store with memory ready: accept T, write T+1, next accept T+2.
  - Load with memory ready: accept T, ren T+1, rdata T+2, o_wb_valid T+3, next accept T+3.
- o_dm_ben=0 and o_dm_wdata=0 whenever no access is in REQ.
- Reset mid-REQ/RESP: no strobe and no wb pulse after reset asserts.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - state encoding: IDLE, REQ, RESP.
  - exception cause codes.
- One combinational sub-module, lsu_load_align: inputs rdata, addr[1:0], funct3; output extended data.

Test Plan:
- SB addr=0x0000_1003, wdata=0x0000_00AB, mem ready -> T+1: o_dm_wen=1 for one cycle, o_dm_addr=0x0400, ben=1000, wdata=0xABABABAB; o_ready=1 at T+2.
- LB addr=0x1003, rdata=0x80123456 -> o_wb_valid at T+3 with o_wb_data=0xFFFFFF80. Same with LBU -> 0x00000080; LHU addr=0x1002 -> 0x00008012.
- LW addr=0x2002 -> o_exc at T+1, cause=0, o_exc_addr=0x2002; no ren/wen ever; o_ready=1 at T+1. SH addr=0x3 -> cause=1. Load funct3=3 -> cause=2.
- SW with i_mem_ready low for 3 cycles -> no wen while low; exactly one wen cycle when ready rises; addr/ben/wdata stable throughout REQ.
- Load accepted, i_rst_n pulsed low during RESP -> no o_wb_valid; all outputs 0; o_ready=1 after release; next request proceeds normally.
- Back-to-back SW, LW, SW with i_valid held high -> accepts at T, T+2, T+5; memory strobes in order, with no overlap.
